// File: rtl/pt2262_pkg.sv
// Shared types and widths for the PT2262 transmit path (scheduler, encoder, decoder).
package pt2262_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RELEASE,
    GAP
  } state_t;
endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module arbitro_rr #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int w_j;

  // Walk from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % N_REQ;
      if (i_req[IDX_W'(w_j)]) begin
        o_onehot               = '0;
        o_onehot[IDX_W'(w_j)]  = 1'b1;
        o_idx                  = IDX_W'(w_j);
        o_valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalonador_tx_pt2262.sv
// Round-robin scheduler sharing one PT2262 encoder; sends N_REP frames per grant.
// state     | meaning
// IDLE      | wait for any request
// ARB       | round-robin pick, register grant
// LOAD      | latch winner address/data
// START     | issue one enc_start pulse
// WAIT_BUSY | wait for encoder busy, with timeout
// WAIT_DONE | wait for busy to fall, count frame
// RELEASE   | done pulse, drop grant, advance pointer
// GAP       | guard idle time before next arbitration
module escalonador_tx_pt2262
  import pt2262_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_REP   = 4,
  parameter int GAP_CYC = 64,
  parameter int TO_CYC  = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [ADDR_W*N_REQ-1:0] i_req_a,
  input  logic [DATA_W*N_REQ-1:0] i_req_d,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_done,
  output logic                    o_err,
  output logic [ADDR_W-1:0]       o_enc_a,
  output logic [DATA_W-1:0]       o_enc_d,
  output logic                    o_enc_start,
  input  logic                    i_enc_busy,
  output logic                    o_tx_en
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int REP_W = $clog2(N_REP + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TO_W  = $clog2(TO_CYC + 1);

  state_t             r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_gnt, r_done;
  logic [IDX_W-1:0]   r_win, r_ptr;
  logic [REP_W-1:0]   r_rep_cnt, w_rep_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic [TO_W-1:0]    r_to_cnt, w_to_nxt;
  logic [ADDR_W-1:0]  r_enc_a;
  logic [DATA_W-1:0]  r_enc_d;
  logic               r_err, r_enc_start, r_tx_en;
  logic               w_timeout, w_frame_end;
  logic [N_REQ-1:0]   w_arb_onehot;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;

  arbitro_rr #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = (r_to_cnt  == TO_W'(TO_CYC))   ? r_to_cnt  : r_to_cnt  + TO_W'(1);
    w_rep_nxt   = (r_rep_cnt == REP_W'(N_REP))   ? r_rep_cnt : r_rep_cnt + REP_W'(1);
    w_gap_nxt   = (r_gap_cnt == GAP_W'(GAP_CYC)) ? r_gap_cnt : r_gap_cnt + GAP_W'(1);
    w_timeout   = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE:      if (|i_req) w_state_nxt = ARB;
      ARB:       w_state_nxt = w_arb_valid ? LOAD : IDLE;
      LOAD:      w_state_nxt = START;
      START:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_enc_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (w_to_nxt == TO_W'(TO_CYC)) begin
          w_timeout   = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      // Entered only with busy high, so busy low here is the falling edge.
      WAIT_DONE: begin
        if (!i_enc_busy) begin
          w_frame_end = 1'b1;
          w_state_nxt = (w_rep_nxt == REP_W'(N_REP)) ? RELEASE : START;
        end
      end
      RELEASE:   w_state_nxt = GAP;
      GAP:       if (w_gap_nxt == GAP_W'(GAP_CYC)) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_enc_start <= 1'b0;
      r_tx_en     <= 1'b0;
      r_enc_a     <= '0;
      r_enc_d     <= '0;
      r_win       <= '0;
      r_ptr       <= '0;
      r_rep_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_done      <= '0;
      r_err       <= 1'b0;
      r_enc_start <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_arb_valid) begin
            r_gnt   <= w_arb_onehot;
            r_win   <= w_arb_idx;
            r_tx_en <= 1'b1;
          end
        end
        LOAD: begin
          r_enc_a <= i_req_a[ADDR_W*int'(r_win) +: ADDR_W];
          r_enc_d <= i_req_d[DATA_W*int'(r_win) +: DATA_W];
        end
        START: begin
          r_enc_start <= 1'b1;
          r_to_cnt    <= '0;
        end
        WAIT_BUSY: begin
          r_to_cnt <= w_to_nxt;
          r_err    <= w_timeout;
        end
        WAIT_DONE: if (w_frame_end) r_rep_cnt <= w_rep_nxt;
        RELEASE: begin
          r_done    <= r_gnt;
          r_gnt     <= '0;
          r_tx_en   <= 1'b0;
          r_ptr     <= (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + IDX_W'(1);
          r_rep_cnt <= '0;
          r_gap_cnt <= '0;
        end
        GAP:     r_gap_cnt <= w_gap_nxt;
        default: ;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_enc_a     = r_enc_a;
  assign o_enc_d     = r_enc_d;
  assign o_enc_start = r_enc_start;
  assign o_tx_en     = r_tx_en;

endmodule

// File: tb/tb_escalonador_tx_pt2262.sv
// Scoreboard bench: expected frames/done pulses queued at stimulus time, popped on DUT events.
module tb_escalonador_tx_pt2262;
  localparam int N_REQ    = 4;
  localparam int N_REP    = 4;
  localparam int BUSY_LEN = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [15:0] req_d;
  logic [3:0]  gnt, done;
  logic        err, enc_start, enc_busy, tx_en;
  logic [7:0]  enc_a;
  logic [3:0]  enc_d;
  logic        enc_dead;
  int          bcnt;

  logic [7:0] a_tb[4];
  logic [3:0] d_tb[4];
  assign req_a = {a_tb[3], a_tb[2], a_tb[1], a_tb[0]};
  assign req_d = {d_tb[3], d_tb[2], d_tb[1], d_tb[0]};

  always #5 clk = ~clk;

  escalonador_tx_pt2262 #(.N_REQ(4), .N_REP(4), .GAP_CYC(64), .TO_CYC(255)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_a     (req_a),
    .i_req_d     (req_d),
    .o_gnt       (gnt),
    .o_done      (done),
    .o_err       (err),
    .o_enc_a     (enc_a),
    .o_enc_d     (enc_d),
    .o_enc_start (enc_start),
    .i_enc_busy  (enc_busy),
    .o_tx_en     (tx_en)
  );

  // Encoder model: busy for BUSY_LEN cycles after each start, or never when dead.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_busy <= 1'b0;
      bcnt     <= 0;
    end else if (enc_start && !enc_dead) begin
      enc_busy <= 1'b1;
      bcnt     <= BUSY_LEN;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) enc_busy <= 1'b0;
    end
  end

  typedef struct { logic [7:0] a; logic [3:0] d; logic [3:0] g; } frm_t;
  typedef struct { logic [3:0] g; int n; } dn_t;
  frm_t q_frm[$];
  dn_t  q_done[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, m_ptr = 0;
  int n_done = 0, n_err = 0, n_start = 0, n_st_grant = 0;
  int done_cyc = 0, err_cyc = 0, gnt_rise_cyc = 0, first_start_cyc = 0, last_gap = 0;
  logic [3:0] gnt_q = '0;
  frm_t f_mon;
  dn_t  d_mon;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 4'h0 && gnt_q == 4'h0) begin
        gnt_rise_cyc = cyc;
        last_gap     = cyc - done_cyc;
        n_st_grant   = 0;
      end
      if (enc_start) begin
        n_start++;
        n_st_grant++;
        if (n_st_grant == 1) first_start_cyc = cyc;
        check("start_expected", 32'(q_frm.size() != 0), 1);
        if (q_frm.size() != 0) begin
          f_mon = q_frm.pop_front();
          check("enc_a", 32'(enc_a), 32'(f_mon.a));
          check("enc_d", 32'(enc_d), 32'(f_mon.d));
          check("gnt", 32'(gnt), 32'(f_mon.g));
          check("tx_en_on", 32'(tx_en), 1);
        end
      end
      if (done != 4'h0) begin
        n_done++;
        done_cyc = cyc;
        check("done_expected", 32'(q_done.size() != 0), 1);
        if (q_done.size() != 0) begin
          d_mon = q_done.pop_front();
          check("done", 32'(done), 32'(d_mon.g));
          check("frames", n_st_grant, d_mon.n);
          check("tx_en_off", 32'(tx_en), 0);
          check("gnt_off", 32'(gnt), 0);
        end
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
    gnt_q = gnt;
  end

  function automatic int pick(input logic [3:0] rq, input int p);
    int j;
    for (int k = 0; k < N_REQ; k++) begin
      j = (p + k) % N_REQ;
      if (rq[j]) return j;
    end
    return 0;
  endfunction

  task automatic expect_grant(input logic [3:0] rq, input int nfr);
    int   w;
    frm_t f;
    dn_t  e;
    w = pick(rq, m_ptr);
    for (int i = 0; i < nfr; i++) begin
      f.a = a_tb[w];
      f.d = d_tb[w];
      f.g = 4'(1 << w);
      q_frm.push_back(f);
    end
    e.g = 4'(1 << w);
    e.n = nfr;
    q_done.push_back(e);
    m_ptr = (w + 1) % N_REQ;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int prev;
    prev = n_done;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_done != prev) return;
    end
    check(tag, n_done, prev + 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int prev;
    prev = n_start;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_start - prev >= target) return;
    end
    check(tag, n_start - prev, target);
  endtask

  initial begin
    int rq_cyc, ne, dn;
    rst_n    = 1'b1;
    req      = 4'h0;
    enc_dead = 1'b0;
    a_tb[0] = 8'h3C; a_tb[1] = 8'h5A; a_tb[2] = 8'hC3; a_tb[3] = 8'h96;
    d_tb[0] = 4'h1;  d_tb[1] = 4'h6;  d_tb[2] = 4'hB;  d_tb[3] = 4'hE;
    #2 rst_n = 1'b0;
    idle(2);
    check("reset_out", 32'({gnt, done, err, enc_a, enc_d, enc_start, tx_en}), 0);
    rst_n = 1'b1;
    idle(2);

    // contention: all four held, expect 0,1,2,3,0 with back-to-back gaps
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      expect_grant(req, N_REP);
      wait_done("cont_done_wait", 700);
      if (g > 0) check("cont_gap", last_gap, 66);
    end
    req = 4'h0;
    idle(80);

    // single requester, held for two grants
    a_tb[0] = 8'hA5; d_tb[0] = 4'h9;
    rq_cyc = cyc;
    req = 4'h1;
    expect_grant(req, N_REP);
    wait_done("single_done_wait", 700);
    check("lat_gnt", gnt_rise_cyc - rq_cyc, 2);
    check("lat_start", first_start_cyc - rq_cyc, 4);
    expect_grant(req, N_REP);
    wait_done("single2_done_wait", 700);
    check("single_gap", last_gap, 66);
    req = 4'h0;
    idle(80);

    // request dropped after the first frame starts
    req = 4'h4;
    expect_grant(req, N_REP);
    wait_starts("drop_start_wait", 1, 200);
    req = 4'h0;
    wait_done("drop_done_wait", 700);
    idle(80);

    // encoder never answers
    enc_dead = 1'b1;
    ne = n_err;
    req = 4'h8;
    expect_grant(req, 1);
    wait_done("to_done_wait", 700);
    check("to_err_cnt", n_err - ne, 1);
    check("to_err_lat", err_cyc - first_start_cyc, 255);
    check("to_done_lat", done_cyc - err_cyc, 1);
    req = 4'h0;
    enc_dead = 1'b0;
    idle(80);

    // inputs change during frame 2
    a_tb[1] = 8'h0F;
    req = 4'h2;
    expect_grant(req, N_REP);
    wait_starts("chg_start_wait", 2, 300);
    a_tb[1] = 8'hF0;
    d_tb[1] = 4'hC;
    wait_done("chg_done_wait", 700);
    req = 4'h0;
    idle(80);

    // async reset during frame 3, then fresh arbitration from pointer 0
    req = 4'hF;
    expect_grant(req, N_REP);
    check("rst_pre_ptr", m_ptr, 3);
    wait_starts("rst_start_wait", 3, 400);
    idle(10);
    #1 rst_n = 1'b0;
    #1 check("rst_async", 32'({gnt, tx_en, enc_start, done}), 0);
    q_frm.delete();
    q_done.delete();
    dn = n_done;
    idle(3);
    rst_n = 1'b1;
    check("rst_no_done", n_done, dn);
    m_ptr = 0;
    expect_grant(req, N_REP);
    wait_done("rst_done_wait", 700);
    req = 4'h0;
    idle(5);

    check("q_frm_empty", q_frm.size(), 0);
    check("q_done_empty", q_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
